// File: rtl/mse_port_io_pkg.sv
// Shared opcodes, FSM state and command layout for the MSE GPIO bank.
package mse_port_io_pkg;

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] OP_WR_OUT = 2'b00;
    localparam logic [1:0] OP_WR_DIR = 2'b01;
    localparam logic [1:0] OP_RD_IN  = 2'b10;
    localparam logic [1:0] OP_RD_CHG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]       op;
        logic [IDX_W-1:0] idx;
    } cmd_t;

endpackage

// File: rtl/mse_port_sync.sv
// One GPIO port: input synchroniser, previous-value register and sticky change flags.
module mse_port_sync
    import mse_port_io_pkg::*;
#(
    parameter int unsigned PORT_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PORT_W-1:0] pin_i,
    input  logic [PORT_W-1:0] oe_i,
    input  logic              en_i,
    input  logic              clr_i,
    output logic [PORT_W-1:0] sync_o,
    output logic [PORT_W-1:0] flags_o
);

    logic [SYNC_STAGES-1:0][PORT_W-1:0] sync_q;
    logic [PORT_W-1:0]                  prev_q;
    logic [PORT_W-1:0]                  flags_q;
    logic [PORT_W-1:0]                  flags_d;
    logic [PORT_W-1:0]                  chg_c;

    // Input-mode bits that moved this cycle; a clear keeps same-edge changes.
    always_comb begin
        chg_c   = (sync_q[SYNC_STAGES-1] ^ prev_q) & ~oe_i & {PORT_W{en_i}};
        flags_d = (clr_i ? '0 : flags_q) | chg_c;
    end

    // Synchroniser chain, last-value register and flag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= '0;
            flags_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q  <= sync_q[SYNC_STAGES-1];
            flags_q <= flags_d;
        end
    end

    assign sync_o  = sync_q[SYNC_STAGES-1];
    assign flags_o = flags_q;

endmodule

// File: rtl/mse_port_io.sv
// MSE GPIO bank: byte-command host interface, per-bit direction, change detection, irq.
module mse_port_io
    import mse_port_io_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 10,
    parameter int unsigned PORT_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        MSE_SCLK,
    input  logic                        MSE_RESETN,
    input  logic [BYTE_W-1:0]           rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic [BYTE_W-1:0]           tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    input  logic [NUM_PORTS*PORT_W-1:0] port_in,
    output logic [NUM_PORTS*PORT_W-1:0] port_out,
    output logic [NUM_PORTS*PORT_W-1:0] port_oe,
    output logic                        irq
);

    localparam int unsigned    CNT_W      = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] PRIME_DONE = CNT_W'(SYNC_STAGES + 1);

    state_e                           state_q, state_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0] out_q, out_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0] oe_q, oe_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0] sync_w;
    logic [NUM_PORTS-1:0][PORT_W-1:0] flag_w;
    logic [IDX_W-1:0]                 wr_idx_q, wr_idx_d;
    logic                             wr_dir_q, wr_dir_d;
    logic [BYTE_W-1:0]                tx_data_q, tx_data_d;
    logic                             rx_ready_q, rx_ready_d;
    logic                             tx_valid_q, tx_valid_d;
    logic [CNT_W-1:0]                 prime_q, prime_d;
    logic                             prime_done_c;
    logic [NUM_PORTS-1:0]             sel_c;
    logic [NUM_PORTS-1:0]             clr_c;
    logic [PORT_W-1:0]                rd_sync_c;
    logic [PORT_W-1:0]                rd_flag_c;
    cmd_t                             cmd;

    assign cmd = cmd_t'(rx_data);

    // Per-port synchroniser and change-flag slices.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mse_port_sync #(
            .PORT_W      (PORT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (MSE_SCLK),
            .rst_n   (MSE_RESETN),
            .pin_i   (port_in[p*PORT_W +: PORT_W]),
            .oe_i    (oe_q[p]),
            .en_i    (prime_done_c),
            .clr_i   (clr_c[p]),
            .sync_o  (sync_w[p]),
            .flags_o (flag_w[p])
        );
    end

    // Hold off flag setting until the synchronisers hold real pin samples.
    always_comb begin
        prime_done_c = (prime_q == PRIME_DONE);
        prime_d      = prime_done_c ? prime_q : prime_q + CNT_W'(1);
    end

    // Index decode and read mux; out-of-range indices match nothing and read zero.
    always_comb begin
        sel_c     = '0;
        rd_sync_c = '0;
        rd_flag_c = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (cmd.idx == IDX_W'(p)) begin
                sel_c[p]  = 1'b1;
                rd_sync_c = sync_w[p];
                rd_flag_c = flag_w[p];
            end
        end
    end

    // Command FSM next state, register writes, response capture and flag clear.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        oe_d      = oe_q;
        wr_idx_d  = wr_idx_q;
        wr_dir_d  = wr_dir_q;
        tx_data_d = tx_data_q;
        clr_c     = '0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    wr_idx_d = cmd.idx;
                    case (cmd.op)
                        OP_WR_OUT, OP_WR_DIR: begin
                            state_d  = ST_DATA;
                            wr_dir_d = (cmd.op == OP_WR_DIR);
                        end
                        OP_RD_IN: begin
                            state_d   = ST_RESP;
                            tx_data_d = BYTE_W'(rd_sync_c);
                        end
                        default: begin
                            state_d   = ST_RESP;
                            tx_data_d = BYTE_W'(rd_flag_c);
                            clr_c     = sel_c;
                        end
                    endcase
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    state_d = ST_IDLE;
                    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                        if (wr_idx_q == IDX_W'(p)) begin
                            if (wr_dir_q) begin
                                oe_d[p] = rx_data[PORT_W-1:0];
                            end else begin
                                out_d[p] = rx_data[PORT_W-1:0];
                            end
                        end
                    end
                end
            end
            ST_RESP: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rx_ready_d = (state_d != ST_RESP);
        tx_valid_d = (state_d == ST_RESP);
    end

    // State and host-visible registers.
    always_ff @(posedge MSE_SCLK or negedge MSE_RESETN) begin
        if (!MSE_RESETN) begin
            state_q    <= ST_IDLE;
            out_q      <= '0;
            oe_q       <= '0;
            wr_idx_q   <= '0;
            wr_dir_q   <= 1'b0;
            tx_data_q  <= '0;
            rx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            prime_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            wr_idx_q   <= wr_idx_d;
            wr_dir_q   <= wr_dir_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            prime_q    <= prime_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign port_out = out_q;
    assign port_oe  = oe_q;
    assign irq      = |flag_w;

endmodule

// File: tb/tb_mse_port_io.sv
// Randomised bench for mse_port_io with a transaction-level reference model.
module tb_mse_port_io;

    localparam int unsigned NP = 10;
    localparam int unsigned PW = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned BW = NP * PW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [BW-1:0] port_in;
    logic [BW-1:0] port_out;
    logic [BW-1:0] port_oe;
    logic          irq;

    int n_vec = 0;
    int n_err = 0;

    mse_port_io #(
        .NUM_PORTS   (NP),
        .PORT_W      (PW),
        .SYNC_STAGES (SS)
    ) dut (
        .MSE_SCLK   (clk),
        .MSE_RESETN (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .port_in    (port_in),
        .port_out   (port_out),
        .port_oe    (port_oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin history, register images, pending transaction.
    logic [PW-1:0] m_out  [NP];
    logic [PW-1:0] m_oe   [NP];
    logic [PW-1:0] m_flag [NP];
    logic [BW-1:0] m_hist [SS+1];
    int            m_edges;
    bit            m_expect_data;
    int            m_widx;
    bit            m_wdir;
    bit            m_pending;
    logic [7:0]    m_tx;
    logic [BW-1:0] m_sync_now;
    logic [BW-1:0] m_chg_all;
    logic [PW-1:0] m_chg  [NP];
    int            m_idx;

    function automatic logic [BW-1:0] flat(input logic [PW-1:0] a [NP]);
        logic [BW-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) v[p*PW +: PW] = a[p];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                m_out[p]  = '0;
                m_oe[p]   = '0;
                m_flag[p] = '0;
            end
            for (int k = 0; k <= SS; k++) m_hist[k] = '0;
            m_edges       = 0;
            m_expect_data = 0;
            m_widx        = 0;
            m_wdir        = 0;
            m_pending     = 0;
            m_tx          = 8'h00;
        end else begin
            m_edges++;
            // A pin move between samples visible SS and SS+1 edges ago is seen now.
            m_sync_now = m_hist[SS-1];
            m_chg_all  = (m_edges >= SS + 2) ? (m_hist[SS-1] ^ m_hist[SS]) : '0;
            for (int p = 0; p < NP; p++) m_chg[p] = m_chg_all[p*PW +: PW] & ~m_oe[p];
            if (m_pending) begin
                if (tx_ready) m_pending = 0;
            end else if (rx_valid) begin
                if (m_expect_data) begin
                    m_expect_data = 0;
                    if (m_widx < NP) begin
                        if (m_wdir) m_oe[m_widx] = rx_data[PW-1:0];
                        else        m_out[m_widx] = rx_data[PW-1:0];
                    end
                end else begin
                    m_idx = int'(rx_data[5:0]);
                    case (rx_data[7:6])
                        2'b00, 2'b01: begin
                            m_expect_data = 1;
                            m_widx        = m_idx;
                            m_wdir        = rx_data[6];
                        end
                        2'b10: begin
                            m_pending = 1;
                            m_tx      = (m_idx < NP) ? 8'(m_sync_now[m_idx*PW +: PW]) : 8'h00;
                        end
                        default: begin
                            m_pending = 1;
                            m_tx      = (m_idx < NP) ? 8'(m_flag[m_idx]) : 8'h00;
                            if (m_idx < NP) m_flag[m_idx] = '0;
                        end
                    endcase
                end
            end
            for (int p = 0; p < NP; p++) m_flag[p] = m_flag[p] | m_chg[p];
            for (int k = SS; k >= 1; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = port_in;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic any_flag;
        any_flag = 1'b0;
        for (int p = 0; p < NP; p++) any_flag = any_flag | (|m_flag[p]);
        chk("rx_ready", 128'(rx_ready), 128'(!m_pending));
        chk("tx_valid", 128'(tx_valid), 128'(m_pending));
        if (m_pending || !rst_n) chk("tx_data", 128'(tx_data), 128'(m_tx));
        chk("port_out", 128'(port_out), 128'(flat(m_out)));
        chk("port_oe", 128'(port_oe), 128'(flat(m_oe)));
        chk("irq", 128'(irq), 128'(any_flag));
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 128'(rx_ready), 128'(1));
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("resp_valid", 128'(tx_valid), 128'(1));
        d        = tx_data;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]    d;
        logic [BW-1:0] e_out;
        logic [BW-1:0] e_oe;
        int            b;

        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        port_in  = '1;
        repeat (3) @(negedge clk);
        chk("rst_oe", 128'(port_oe), 128'(0));
        chk("rst_out", 128'(port_out), 128'(0));
        chk("rst_rx_ready", 128'(rx_ready), 128'(1));
        chk("rst_tx_valid", 128'(tx_valid), 128'(0));
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_irq_idle", 128'(irq), 128'(0));
        send(8'hC0);
        get_resp(d);
        chk("rst_chg0", 128'(d), 128'(8'h00));
        chk("rst_irq", 128'(irq), 128'(0));

        // Direction then output register writes on port 3.
        send(8'h43);
        send(8'h0F);
        chk("wr_dir3", 128'(port_oe[3*PW +: PW]), 128'(8'h0F));
        send(8'h03);
        send(8'hA5);
        e_out = '0;
        e_out[3*PW +: PW] = 8'hA5;
        e_oe = '0;
        e_oe[3*PW +: PW] = 8'h0F;
        chk("wr_out3", 128'(port_out), 128'(e_out));

        // Input latency and change flags on port 5.
        @(negedge clk);
        port_in[5*PW +: PW] = 8'h3C;
        repeat (SS + 1) @(posedge clk);
        send(8'h85);
        get_resp(d);
        chk("rd_in5", 128'(d), 128'(8'h3C));
        send(8'hC5);
        get_resp(d);
        chk("rd_chg5", 128'(d), 128'(8'hC3));
        chk("irq_after_c5", 128'(irq), 128'(0));

        // Single-bit toggle on port 2 and read-clear.
        @(negedge clk);
        port_in[2*PW + 1] = 1'b0;
        repeat (SS) @(posedge clk);
        #1 chk("irq_early", 128'(irq), 128'(0));
        @(posedge clk);
        #1 chk("irq_set", 128'(irq), 128'(1));
        send(8'hC2);
        get_resp(d);
        chk("rd_chg2", 128'(d), 128'(8'h02));
        chk("irq_clr", 128'(irq), 128'(0));

        // Change detected on the same edge as the clearing read survives it.
        @(negedge clk);
        port_in[2*PW + 1] = 1'b1;
        repeat (SS) @(posedge clk);
        send(8'hC2);
        get_resp(d);
        chk("rd_chg2_race", 128'(d), 128'(8'h00));
        chk("irq_race", 128'(irq), 128'(1));
        send(8'hC2);
        get_resp(d);
        chk("rd_chg2_kept", 128'(d), 128'(8'h02));

        // Out-of-range index.
        send(8'h3F);
        send(8'h55);
        chk("oor_out", 128'(port_out), 128'(e_out));
        chk("oor_oe", 128'(port_oe), 128'(e_oe));
        send(8'hBF);
        get_resp(d);
        chk("oor_rd", 128'(d), 128'(8'h00));

        // Response back-pressure while pins keep moving.
        tx_ready = 1'b0;
        send(8'h85);
        port_in[5*PW +: PW] = 8'h3D;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_rx_ready", 128'(rx_ready), 128'(0));
            chk("bp_tx_valid", 128'(tx_valid), 128'(1));
            chk("bp_tx_data", 128'(tx_data), 128'(8'h3C));
        end
        get_resp(d);
        chk("bp_resp", 128'(d), 128'(8'h3C));

        // Reset between a write command and its data byte.
        send(8'h01);
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(8'hAA);
        get_resp(d);
        chk("rst_mid_resp", 128'(d), 128'(8'h00));
        chk("rst_mid_oe1", 128'(port_oe[PW +: PW]), 128'(0));

        // Random traffic checked by the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rx_valid = ($urandom_range(0, 3) != 0);
            b = int'($urandom_range(0, 15));
            rx_data = {2'($urandom_range(0, 3)), 6'((b == 15) ? 63 : b)};
            tx_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) begin
                b = int'($urandom_range(0, BW - 1));
                port_in[b] = ~port_in[b];
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
